// File: rtl/knap_search_engine_if.sv
// knap_search_engine_if
//   Solution stream from the knapsack search engine (master) to its consumer (slave).
//   sol_valid  master -> slave   a passing selection is presented
//   sol_ready  slave  -> master  beat transfers on sol_valid & sol_ready
//   sol_sel    master -> slave   selection vector, bit i = item i
//   sol_value  master -> slave   total value of sol_sel
interface knap_search_engine_if #(
   parameter int unsigned N_ITEMS = 13,
   parameter int unsigned AW      = 12
);
   logic               sol_valid;
   logic               sol_ready;
   logic [N_ITEMS-1:0] sol_sel;
   logic [AW-1:0]      sol_value;

   modport master (output sol_valid, output sol_sel, output sol_value, input sol_ready);
   modport slave  (input sol_valid, input sol_sel, input sol_value, output sol_ready);
endinterface

// File: rtl/knap_search_engine.sv
// knap_search_engine
//   Exhaustive knapsack search. Holds a per-item table (value, weight, volume), enumerates
//   every selection vector in ascending order on start, accumulates one item per cycle and
//   streams each candidate that meets the value floor and weight/volume ceilings.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     i_item_we/idx/...     table write port, accepted only while not busy
//     i_start               start pulse, accepted only while not busy
//     o_busy, o_done        run in progress / one-cycle completion pulse
//     io_sol                solution stream (valid/ready, selection, value)
//     o_best_found/sel/value  best passing selection of the current or last run
//     o_sol_count           number of passing selections of the current or last run
module knap_search_engine #(
   parameter int unsigned N_ITEMS    = 13,
   parameter int unsigned W          = 8,
   parameter int unsigned MIN_VALUE  = 121,
   parameter int unsigned MAX_WEIGHT = 60,
   parameter int unsigned MAX_VOLUME = 60,
   localparam int unsigned IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1,
   localparam int unsigned AW = W + IW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_item_we,
   input  logic [IW-1:0]        i_item_idx,
   input  logic [W-1:0]         i_item_value,
   input  logic [W-1:0]         i_item_weight,
   input  logic [W-1:0]         i_item_volume,
   input  logic                 i_start,
   output logic                 o_busy,
   output logic                 o_done,
   knap_search_engine_if.master io_sol,
   output logic                 o_best_found,
   output logic [N_ITEMS-1:0]   o_best_sel,
   output logic [AW-1:0]        o_best_value,
   output logic [N_ITEMS:0]     o_sol_count
);

   localparam logic [IW-1:0] LastIdx    = IW'(N_ITEMS - 1);
   localparam logic [AW-1:0] MinValueW  = AW'(MIN_VALUE);
   localparam logic [AW-1:0] MaxWeightW = AW'(MAX_WEIGHT);
   localparam logic [AW-1:0] MaxVolumeW = AW'(MAX_VOLUME);

   typedef enum logic [2:0] {StIdle, StAccum, StCheck, StEmit, StDone} state_e;

   state_e r_state;
   state_e w_state_next;

   logic [W-1:0]       r_tbl_val [N_ITEMS];
   logic [W-1:0]       r_tbl_wt  [N_ITEMS];
   logic [W-1:0]       r_tbl_vol [N_ITEMS];

   logic [N_ITEMS-1:0] r_cand;
   logic [IW-1:0]      r_idx;
   logic [AW-1:0]      r_acc_val;
   logic [AW-1:0]      r_acc_wt;
   logic [AW-1:0]      r_acc_vol;
   logic               r_best_found;
   logic [N_ITEMS-1:0] r_best_sel;
   logic [AW-1:0]      r_best_value;
   logic [N_ITEMS:0]   r_sol_count;

   logic               w_ready_for_cmd;
   logic               w_start;
   logic               w_take;
   logic [AW-1:0]      w_sum_val;
   logic [AW-1:0]      w_sum_wt;
   logic [AW-1:0]      w_sum_vol;
   logic               w_prune;
   logic               w_last_item;
   logic               w_last_cand;
   logic               w_pass;
   logic               w_advance;

   // Idle and the done cycle both count as not busy, so commands are taken in either.
   assign w_ready_for_cmd = (r_state == StIdle) || (r_state == StDone);
   assign w_start         = i_start && w_ready_for_cmd;

   assign w_take    = r_cand[r_idx];
   assign w_sum_val = r_acc_val + (w_take ? {{IW{1'b0}}, r_tbl_val[r_idx]} : '0);
   assign w_sum_wt  = r_acc_wt  + (w_take ? {{IW{1'b0}}, r_tbl_wt[r_idx]}  : '0);
   assign w_sum_vol = r_acc_vol + (w_take ? {{IW{1'b0}}, r_tbl_vol[r_idx]} : '0);

   // Sums only grow, so exceeding a ceiling part-way already dooms the candidate.
   assign w_prune     = (w_sum_wt > MaxWeightW) || (w_sum_vol > MaxVolumeW);
   assign w_last_item = (r_idx == LastIdx);
   assign w_last_cand = &r_cand;
   assign w_pass      = (r_acc_val >= MinValueW) && (r_acc_wt <= MaxWeightW) &&
                        (r_acc_vol <= MaxVolumeW);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; w_advance marks "move on to the next candidate"
   always_comb begin
      w_state_next = r_state;
      w_advance    = 1'b0;
      unique case (r_state)
         StIdle:  if (i_start) w_state_next = StAccum;
         StAccum: begin
            if (w_prune)          w_advance    = 1'b1;
            else if (w_last_item) w_state_next = StCheck;
         end
         StCheck: begin
            if (w_pass) w_state_next = StEmit;
            else        w_advance    = 1'b1;
         end
         StEmit:  if (io_sol.sol_ready) w_advance = 1'b1;
         StDone:  w_state_next = i_start ? StAccum : StIdle;
         default: w_state_next = StIdle;
      endcase
      if (w_advance) w_state_next = w_last_cand ? StDone : StAccum;
   end

   // Outputs decoded from state
   always_comb begin
      o_busy           = 1'b0;
      o_done           = 1'b0;
      io_sol.sol_valid = 1'b0;
      io_sol.sol_sel   = '0;
      io_sol.sol_value = '0;
      unique case (r_state)
         StAccum, StCheck: o_busy = 1'b1;
         StEmit: begin
            o_busy           = 1'b1;
            io_sol.sol_valid = 1'b1;
            io_sol.sol_sel   = r_cand;
            io_sol.sol_value = r_acc_val;
         end
         StDone:  o_done = 1'b1;
         default: ;
      endcase
   end

   // Item table
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            r_tbl_val[i] <= '0;
            r_tbl_wt[i]  <= '0;
            r_tbl_vol[i] <= '0;
         end
      end else if (i_item_we && w_ready_for_cmd) begin
         // Out-of-range indices match no entry and are dropped.
         for (int i = 0; i < N_ITEMS; i++) begin
            if (i_item_idx == IW'(i)) begin
               r_tbl_val[i] <= i_item_value;
               r_tbl_wt[i]  <= i_item_weight;
               r_tbl_vol[i] <= i_item_volume;
            end
         end
      end
   end

   // Candidate walk, accumulators and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand       <= '0;
         r_idx        <= '0;
         r_acc_val    <= '0;
         r_acc_wt     <= '0;
         r_acc_vol    <= '0;
         r_best_found <= 1'b0;
         r_best_sel   <= '0;
         r_best_value <= '0;
         r_sol_count  <= '0;
      end else begin
         if (w_start) begin
            r_cand       <= '0;
            r_idx        <= '0;
            r_acc_val    <= '0;
            r_acc_wt     <= '0;
            r_acc_vol    <= '0;
            r_best_found <= 1'b0;
            r_best_sel   <= '0;
            r_best_value <= '0;
            r_sol_count  <= '0;
         end else if (w_advance) begin
            if (!w_last_cand) r_cand <= r_cand + 1'b1;
            r_idx     <= '0;
            r_acc_val <= '0;
            r_acc_wt  <= '0;
            r_acc_vol <= '0;
         end else if (r_state == StAccum) begin
            r_acc_val <= w_sum_val;
            r_acc_wt  <= w_sum_wt;
            r_acc_vol <= w_sum_vol;
            if (!w_last_item) r_idx <= r_idx + 1'b1;
         end

         if ((r_state == StCheck) && w_pass) begin
            r_sol_count <= r_sol_count + 1'b1;
            // Strictly greater: on ties the earlier (lower) candidate stays best.
            if (!r_best_found || (r_acc_val > r_best_value)) begin
               r_best_found <= 1'b1;
               r_best_sel   <= r_cand;
               r_best_value <= r_acc_val;
            end
         end
      end
   end

   assign o_best_found = r_best_found;
   assign o_best_sel   = r_best_sel;
   assign o_best_value = r_best_value;
   assign o_sol_count  = r_sol_count;

endmodule

// File: tb/tb_knap_search_engine.sv
// tb_knap_search_engine
//   Four engine instances: three small (3-item) configurations and one at default size.
//   A reference model enumerates selections with plain arithmetic and predicts the beat
//   stream, best result, count and busy cycles; a negedge process compares against it.
module tb_knap_search_engine;

   localparam int NDUT = 4;

   function automatic int cfg_n(input int g);
      return (g == 3) ? 13 : 3;
   endfunction
   function automatic int cfg_min(input int g);
      case (g)
         0:       return 10;
         1:       return 0;
         2:       return 5;
         default: return 121;
      endcase
   endfunction
   function automatic int cfg_maxw(input int g);
      return (g == 3) ? 60 : 10;
   endfunction
   function automatic int cfg_maxv(input int g);
      return (g == 3) ? 60 : 10;
   endfunction

   logic       clk = 1'b0;
   logic       rst_n;
   logic       item_we;
   logic       start;
   logic [3:0] item_idx;
   logic [7:0] item_value;
   logic [7:0] item_weight;
   logic [7:0] item_volume;
   int         dut_sel;
   logic       ready [NDUT];

   logic        busy       [NDUT];
   logic        done       [NDUT];
   logic        sol_valid  [NDUT];
   logic        best_found [NDUT];
   logic [12:0] sol_sel    [NDUT];
   logic [12:0] best_sel   [NDUT];
   logic [11:0] sol_value  [NDUT];
   logic [11:0] best_value [NDUT];
   logic [13:0] sol_count  [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int unsigned N  = cfg_n(g);
      localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
      localparam int unsigned AW = 8 + IW;

      logic          w_busy;
      logic          w_done;
      logic          w_best_found;
      logic [N-1:0]  w_best_sel;
      logic [AW-1:0] w_best_value;
      logic [N:0]    w_sol_count;

      knap_search_engine_if #(.N_ITEMS(N), .AW(AW)) u_if ();

      knap_search_engine #(
         .N_ITEMS   (N),
         .W         (8),
         .MIN_VALUE (cfg_min(g)),
         .MAX_WEIGHT(cfg_maxw(g)),
         .MAX_VOLUME(cfg_maxv(g))
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_item_we    (item_we && (dut_sel == g)),
         .i_item_idx   (item_idx[IW-1:0]),
         .i_item_value (item_value),
         .i_item_weight(item_weight),
         .i_item_volume(item_volume),
         .i_start      (start && (dut_sel == g)),
         .o_busy       (w_busy),
         .o_done       (w_done),
         .io_sol       (u_if),
         .o_best_found (w_best_found),
         .o_best_sel   (w_best_sel),
         .o_best_value (w_best_value),
         .o_sol_count  (w_sol_count)
      );

      assign u_if.sol_ready = ready[g];
      assign busy[g]        = w_busy;
      assign done[g]        = w_done;
      assign best_found[g]  = w_best_found;
      assign sol_valid[g]   = u_if.sol_valid;
      assign sol_sel[g]     = 13'(u_if.sol_sel);
      assign sol_value[g]   = 12'(u_if.sol_value);
      assign best_sel[g]    = 13'(w_best_sel);
      assign best_value[g]  = 12'(w_best_value);
      assign sol_count[g]   = 14'(w_sol_count);
   end

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int d;
      int sel;
      int val;
   } beat_t;
   beat_t exp_q[$];

   int mdl_val [NDUT][13];
   int mdl_wt  [NDUT][13];
   int mdl_vol [NDUT][13];
   int exp_cnt    [NDUT];
   int exp_found  [NDUT];
   int exp_bsel   [NDUT];
   int exp_bval   [NDUT];
   int exp_cycles [NDUT];
   bit expect_done [NDUT];

   int done_cnt  [NDUT];
   int busy_cnt  [NDUT];
   int base_done [NDUT];
   int base_busy [NDUT];
   bit hold_act  [NDUT];
   int held_sel  [NDUT];
   int held_val  [NDUT];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: full enumeration from the table; also predicts busy cycles with ready=1.
   task automatic build_expect(input int d);
      int n, v, w, vol, cost;
      bit pruned, pass;
      n = cfg_n(d);
      exp_cnt[d] = 0; exp_found[d] = 0; exp_bsel[d] = 0; exp_bval[d] = 0; exp_cycles[d] = 0;
      for (int c = 0; c < (1 << n); c++) begin
         v = 0; w = 0; vol = 0; pruned = 0; cost = 0;
         for (int i = 0; i < n; i++) begin
            if (c[i]) begin
               v += mdl_val[d][i]; w += mdl_wt[d][i]; vol += mdl_vol[d][i];
               if (w > cfg_maxw(d) || vol > cfg_maxv(d)) begin
                  pruned = 1;
                  cost   = i + 1;
                  break;
               end
            end
         end
         pass = !pruned && (v >= cfg_min(d));
         if (!pruned) cost = n + 1 + (pass ? 1 : 0);
         exp_cycles[d] += cost;
         if (pass) begin
            exp_q.push_back('{d, c, v});
            exp_cnt[d]++;
            if (exp_found[d] == 0 || v > exp_bval[d]) begin
               exp_found[d] = 1; exp_bsel[d] = c; exp_bval[d] = v;
            end
         end
      end
   endtask

   task automatic write_item(input int d, input int idx, input int v, input int w,
                             input int vol, input bit honoured);
      dut_sel     = d;
      item_we     = 1'b1;
      item_idx    = 4'(idx);
      item_value  = 8'(v);
      item_weight = 8'(w);
      item_volume = 8'(vol);
      tick();
      item_we = 1'b0;
      if (honoured && idx < cfg_n(d)) begin
         mdl_val[d][idx] = v; mdl_wt[d][idx] = w; mdl_vol[d][idx] = vol;
      end
   endtask

   task automatic run_start(input int d);
      build_expect(d);
      expect_done[d] = 1'b1;
      base_done[d]   = done_cnt[d];
      base_busy[d]   = busy_cnt[d];
      dut_sel = d;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", busy[d], 1);
   endtask

   task automatic wait_done(input int d, input int budget, input bit check_cycles);
      int k = 0;
      while (done_cnt[d] == base_done[d] && k < budget) begin
         tick();
         k++;
      end
      check("done_pulses", done_cnt[d] - base_done[d], 1);
      expect_done[d] = 1'b0;
      check("busy_after_done", busy[d], 0);
      if (check_cycles) check("busy_cycles", busy_cnt[d] - base_busy[d], exp_cycles[d]);
   endtask

   task automatic wait_valid(input int d, input int budget);
      int k = 0;
      while (!sol_valid[d] && k < budget) begin
         tick();
         k++;
      end
      check("valid_in_time", sol_valid[d], 1);
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (!rst_n) begin
            hold_act[d] = 1'b0;
         end else begin
            if (busy[d]) busy_cnt[d]++;
            if (hold_act[d]) begin
               check("hold_valid", sol_valid[d], 1);
               if (sol_valid[d]) begin
                  check("hold_sel", sol_sel[d], held_sel[d]);
                  check("hold_value", sol_value[d], held_val[d]);
               end
               hold_act[d] = 1'b0;
            end
            if (sol_valid[d]) begin
               if (ready[d]) begin
                  if (exp_q.size() == 0 || exp_q[0].d != d) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL beat_unexpected: dut %0d sel %0h value %0d, none expected",
                              d, sol_sel[d], sol_value[d]);
                  end else begin
                     beat_t b;
                     b = exp_q.pop_front();
                     check("beat_sel", sol_sel[d], b.sel);
                     check("beat_value", sol_value[d], b.val);
                  end
               end else begin
                  hold_act[d] = 1'b1;
                  held_sel[d] = int'(sol_sel[d]);
                  held_val[d] = int'(sol_value[d]);
               end
            end
            if (done[d]) begin
               done_cnt[d]++;
               if (!expect_done[d]) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL done_unexpected: dut %0d pulsed done, none expected", d);
               end else begin
                  check("done_count", sol_count[d], exp_cnt[d]);
                  check("done_found", best_found[d], exp_found[d]);
                  check("done_best_sel", best_sel[d], exp_bsel[d]);
                  check("done_best_value", best_value[d], exp_bval[d]);
                  check("beats_missing", exp_q.size(), 0);
               end
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n = 1'b1; item_we = 1'b0; start = 1'b0; dut_sel = 0;
      item_idx = '0; item_value = '0; item_weight = '0; item_volume = '0;
      for (int d = 0; d < NDUT; d++) begin
         ready[d] = 1'b1; expect_done[d] = 1'b0; done_cnt[d] = 0; busy_cnt[d] = 0;
         hold_act[d] = 1'b0; held_sel[d] = 0; held_val[d] = 0;
         for (int i = 0; i < 13; i++) begin
            mdl_val[d][i] = 0; mdl_wt[d][i] = 0; mdl_vol[d][i] = 0;
         end
      end
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check("rst_busy", busy[d], 0);
         check("rst_done", done[d], 0);
         check("rst_valid", sol_valid[d], 0);
         check("rst_found", best_found[d], 0);
         check("rst_best_sel", best_sel[d], 0);
         check("rst_best_value", best_value[d], 0);
         check("rst_count", sol_count[d], 0);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single passing selection 3'b011 (value 11); idx 3 is out of range and dropped.
      write_item(0, 0, 5, 4, 4, 1);
      write_item(0, 1, 6, 5, 3, 1);
      write_item(0, 2, 9, 7, 2, 1);
      write_item(0, 3, 99, 0, 0, 1);
      run_start(0);
      wait_done(0, 200, 1);
      check("t1_count", sol_count[0], 1);
      check("t1_best_sel", best_sel[0], 3);
      check("t1_best_value", best_value[0], 11);
      check("t1_found", best_found[0], 1);
      check("t1_cycles_model", exp_cycles[0], 30);

      // start and table write while busy are ignored.
      run_start(0);
      tick(); tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      write_item(0, 0, 50, 0, 0, 0);
      check("midrun_busy", busy[0], 1);
      wait_done(0, 200, 1);
      check("midrun_count", sol_count[0], 1);

      // Back-pressure: beat held 20 cycles, no done meanwhile.
      ready[0] = 1'b0;
      run_start(0);
      wait_valid(0, 100);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("stall_valid", sol_valid[0], 1);
         check("stall_sel", sol_sel[0], 3);
         check("stall_no_done", done_cnt[0] - base_done[0], 0);
      end
      ready[0] = 1'b1;
      wait_done(0, 100, 0);

      // Zero table, floor 0: all eight selections pass in order, earliest wins ties.
      run_start(1);
      wait_done(1, 200, 1);
      check("t3_count", sol_count[1], 8);
      check("t3_best_sel", best_sel[1], 0);
      check("t3_best_value", best_value[1], 0);

      // Heavy item 2 prunes every selection containing it.
      write_item(2, 0, 5, 1, 1, 1);
      write_item(2, 1, 5, 1, 1, 1);
      write_item(2, 2, 0, 20, 0, 1);
      run_start(2);
      wait_done(2, 200, 1);
      check("t4_count", sol_count[2], 3);
      check("t4_best_sel", best_sel[2], 3);
      check("t4_best_value", best_value[2], 10);

      // Reset while a beat is stalled: everything clears at once, no done afterwards.
      ready[0] = 1'b0;
      run_start(0);
      wait_valid(0, 100);
      tick();
      #3 rst_n = 1'b0;
      exp_q.delete();
      expect_done[0] = 1'b0;
      for (int d = 0; d < NDUT; d++)
         for (int i = 0; i < 13; i++) begin
            mdl_val[d][i] = 0; mdl_wt[d][i] = 0; mdl_vol[d][i] = 0;
         end
      #1;
      check("rst_mid_valid", sol_valid[0], 0);
      check("rst_mid_busy", busy[0], 0);
      check("rst_mid_count", sol_count[0], 0);
      check("rst_mid_found", best_found[0], 0);
      tick();
      tick();
      rst_n = 1'b1;
      ready[0] = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      check("rst_mid_no_done", done_cnt[0] - base_done[0], 0);

      // Table was cleared by reset: nothing reaches the floor of 10.
      run_start(0);
      wait_done(0, 200, 1);
      check("post_rst_count", sol_count[0], 0);
      check("post_rst_found", best_found[0], 0);

      // Default size: items 0..4 overweight (prune early), items 5..12 worth 20 each.
      // Six light items sum to 120, just under the floor; seven or eight pass.
      for (int i = 0; i < 5; i++) write_item(3, i, 1, 61, 0, 1);
      for (int i = 5; i < 13; i++) write_item(3, i, 20, 7, 7, 1);
      run_start(3);
      wait_done(3, 40000, 1);
      check("t6_count", sol_count[3], 9);
      check("t6_best_sel", best_sel[3], 13'h1FE0);
      check("t6_best_value", best_value[3], 160);
      check("t6_found", best_found[3], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
